// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory-stage controller: opcodes, writeback and
// write-port select values, and the controller state encoding.
package mem_ctrl_pkg;

  localparam logic [4:0] OPC_ALU  = 5'd0;
  localparam logic [4:0] OPC_JAL  = 5'd3;
  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] OPC_SW   = 5'd7;
  localparam logic [4:0] OPC_LW   = 5'd8;
  localparam logic [4:0] OPC_SETX = 5'd21;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DMEM = 2'b01;
  localparam logic [1:0] WB_PC1  = 2'b10;
  localparam logic [1:0] WB_SETX = 2'b11;

  localparam logic [1:0] WP_RD  = 2'b00;
  localparam logic [1:0] WP_R31 = 2'b10;
  localparam logic [1:0] WP_R30 = 2'b01;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // One-hot mask with a single bit set at the given opcode position.
  function automatic logic [31:0] opc_bit(input logic [4:0] opc);
    return 32'd1 << opc;
  endfunction

endpackage

// File: rtl/decoder5to32.sv
// Plain 5-to-32 one-hot decoder.
module decoder5to32 (
  input  logic [4:0]  i_sel,
  output logic [31:0] o_onehot
);

  assign o_onehot = 32'd1 << i_sel;

endmodule

// File: rtl/mem_ctrl_decode.sv
// Combinational opcode-to-control decode. Every control bit is an OR over a
// set of opcodes, so each one is a mask applied to the one-hot opcode.
module mem_ctrl_decode
  import mem_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_rf_we,
  output logic [1:0] o_wb_sel,
  output logic [1:0] o_wp_sel,
  output logic       o_mem_op,
  output logic       o_is_sw
);

  localparam logic [31:0] M_RF_WE = opc_bit(OPC_ALU) | opc_bit(OPC_ADDI) |
                                    opc_bit(OPC_LW) | opc_bit(OPC_JAL) |
                                    opc_bit(OPC_SETX);
  localparam logic [31:0] M_WB1   = opc_bit(OPC_JAL) | opc_bit(OPC_SETX);
  localparam logic [31:0] M_WB0   = opc_bit(OPC_LW) | opc_bit(OPC_SETX);
  localparam logic [31:0] M_WP1   = opc_bit(OPC_JAL);
  localparam logic [31:0] M_WP0   = opc_bit(OPC_SETX);
  localparam logic [31:0] M_MEM   = opc_bit(OPC_SW) | opc_bit(OPC_LW);
  localparam logic [31:0] M_SW    = opc_bit(OPC_SW);

  logic [31:0] w_onehot;

  decoder5to32 u_dec (
    .i_sel    (i_opcode),
    .o_onehot (w_onehot)
  );

  assign o_rf_we  = |(w_onehot & M_RF_WE);
  assign o_wb_sel = {|(w_onehot & M_WB1), |(w_onehot & M_WB0)};
  assign o_wp_sel = {|(w_onehot & M_WP1), |(w_onehot & M_WP0)};
  assign o_mem_op = |(w_onehot & M_MEM);
  assign o_is_sw  = |(w_onehot & M_SW);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Registered memory-stage controller: latches the instruction from execute,
// runs the data-memory req/ready handshake and strobes writeback controls.
// Optional access watchdog is enabled by defining MEM_TIMEOUT_EN.
//
//   state  | meaning
//   EMPTY  | nothing held
//   HOLD   | non-memory instruction held, writeback controls valid
//   ACCESS | memory access outstanding, execute stalled
//   DONE   | memory access finished, writeback controls valid
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int INSN_W        = 32,
  parameter int OPC_W         = 5,
  parameter int TIMEOUT_W     = 8,
  parameter int TIMEOUT_LIMIT = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_valid,
  input  logic [INSN_W-1:0] x_instruction,
  output logic              x_ready,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_WE,
  input  logic              dmem_ready,
  output logic              m_valid,
  output logic [INSN_W-1:0] m_instruction,
  output logic              regfile_WE,
  output logic [1:0]        writebackMux_Select,
  output logic [1:0]        writePortMux_Select,
  output logic              mem_err
);

  state_t            r_state, w_next;
  logic [INSN_W-1:0] r_insn;
  logic              r_rf_we, r_is_sw, r_flushed;
  logic [1:0]        r_wb_sel, r_wp_sel;
  logic              w_accept, w_rf_we, w_mem_op, w_is_sw;
  logic [1:0]        w_wb_sel, w_wp_sel;
  logic              w_tmo, w_tmo_supp;

  mem_ctrl_decode u_decode (
    .i_opcode (x_instruction[INSN_W-1 -: OPC_W]),
    .o_rf_we  (w_rf_we),
    .o_wb_sel (w_wb_sel),
    .o_wp_sel (w_wp_sel),
    .o_mem_op (w_mem_op),
    .o_is_sw  (w_is_sw)
  );

  // Reset gates x_ready so execute sees a stall while the stage is held in reset.
  assign x_ready  = ~reset & ~flush & (r_state != ST_ACCESS);
  assign w_accept = x_valid & x_ready;

  assign dmem_req = (r_state == ST_ACCESS);
  assign dmem_WE  = dmem_req & r_is_sw;
  assign m_valid  = (r_state == ST_HOLD) || (r_state == ST_DONE);

  assign m_instruction       = r_insn;
  assign regfile_WE          = m_valid & r_rf_we & ~w_tmo_supp;
  assign writebackMux_Select = m_valid ? r_wb_sel : 2'b00;
  assign writePortMux_Select = m_valid ? r_wp_sel : 2'b00;

`ifdef MEM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_LIMIT - 1);

  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic                 r_tmo_hit, r_mem_err;

  assign w_tmo      = (r_state == ST_ACCESS) & ~dmem_ready & (r_tmo_cnt == TMO_LAST);
  assign w_tmo_supp = r_tmo_hit;
  assign mem_err    = r_mem_err;

  // Watchdog: counts stalled ACCESS cycles, flags the aborted instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_hit <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tmo_cnt <= '0;
        r_tmo_hit <= 1'b0;
      end else if ((r_state == ST_ACCESS) && !dmem_ready) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_tmo) begin
        r_tmo_hit <= 1'b1;
        r_mem_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign w_tmo_supp = 1'b0;
  assign mem_err    = 1'b0;
`endif

  // Next state; a flushed store keeps its request until memory finishes it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_ACCESS: begin
        if (flush && !r_is_sw)          w_next = ST_EMPTY;
        else if (dmem_ready || w_tmo)   w_next = (flush || r_flushed) ? ST_EMPTY : ST_DONE;
        else                            w_next = ST_ACCESS;
      end
      default: begin
        if (w_accept) w_next = w_mem_op ? ST_ACCESS : ST_HOLD;
        else          w_next = ST_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_next;
  end

  // Held instruction and its decoded controls, plus the flushed-store marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_insn    <= '0;
      r_rf_we   <= 1'b0;
      r_wb_sel  <= 2'b00;
      r_wp_sel  <= 2'b00;
      r_is_sw   <= 1'b0;
      r_flushed <= 1'b0;
    end else if (w_accept) begin
      r_insn    <= x_instruction;
      r_rf_we   <= w_rf_we;
      r_wb_sel  <= w_wb_sel;
      r_wp_sel  <= w_wp_sel;
      r_is_sw   <= w_is_sw;
      r_flushed <= 1'b0;
    end else if ((r_state == ST_ACCESS) && flush) begin
      r_flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a table of back-to-back non-memory
// instructions followed by hand-written memory, flush and reset sequences.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TLIM = 4;
`else
  localparam int TLIM = 200;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        x_valid = 1'b0;
  logic [31:0] x_instruction = '0;
  logic        x_ready;
  logic        flush = 1'b0;
  logic        dmem_req, dmem_WE;
  logic        dmem_ready = 1'b0;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic        regfile_WE;
  logic [1:0]  writebackMux_Select, writePortMux_Select;
  logic        mem_err;

  int n_pass = 0;
  int n_total = 0;

  mem_stage_ctrl #(.INSN_W(32), .OPC_W(5), .TIMEOUT_W(8), .TIMEOUT_LIMIT(TLIM)) dut (
    .clock               (clock),
    .reset               (reset),
    .x_valid             (x_valid),
    .x_instruction       (x_instruction),
    .x_ready             (x_ready),
    .flush               (flush),
    .dmem_req            (dmem_req),
    .dmem_WE             (dmem_WE),
    .dmem_ready          (dmem_ready),
    .m_valid             (m_valid),
    .m_instruction       (m_instruction),
    .regfile_WE          (regfile_WE),
    .writebackMux_Select (writebackMux_Select),
    .writePortMux_Select (writePortMux_Select),
    .mem_err             (mem_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [4:0] opc;
    logic       we;
    logic [1:0] wb;
    logic [1:0] wp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] mk(input logic [4:0] opc, input int salt);
    logic [31:0] pat;
    pat = 32'h0ABC_DEF1 * (salt + 1);
    return {opc, pat[26:0]};
  endfunction

  initial begin
    logic [31:0] insn;
    logic [31:0] prev;

    vecs[0] = '{5'd0,  1'b1, 2'b00, 2'b00};  // ALU
    vecs[1] = '{5'd0,  1'b1, 2'b00, 2'b00};  // ALU
    vecs[2] = '{5'd0,  1'b1, 2'b00, 2'b00};  // ALU
    vecs[3] = '{5'd5,  1'b1, 2'b00, 2'b00};  // addi
    vecs[4] = '{5'd3,  1'b1, 2'b10, 2'b10};  // jal
    vecs[5] = '{5'd21, 1'b1, 2'b11, 2'b01};  // setx
    vecs[6] = '{5'd12, 1'b0, 2'b00, 2'b00};  // undefined opcode
    vecs[7] = '{5'd31, 1'b0, 2'b00, 2'b00};  // undefined opcode

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_x_ready", {31'd0, x_ready}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 0);
    chk("rst_m_insn", m_instruction, 0);
    chk("rst_mem_err", {31'd0, mem_err}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_x_ready", {31'd0, x_ready}, 1);

    // Back-to-back non-memory stream from the table
    prev = '0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        insn = mk(vecs[i].opc, i);
        x_valid = 1'b1;
        x_instruction = insn;
      end else begin
        x_valid = 1'b0;
      end
      #1;
      if (i < 8) chk($sformatf("vec%0d_x_ready", i), {31'd0, x_ready}, 1);
      if (i > 0) begin
        chk($sformatf("vec%0d_m_valid", i-1), {31'd0, m_valid}, 1);
        chk($sformatf("vec%0d_m_insn", i-1), m_instruction, prev);
        chk($sformatf("vec%0d_we", i-1), {31'd0, regfile_WE}, {31'd0, vecs[i-1].we});
        chk($sformatf("vec%0d_wb", i-1), {30'd0, writebackMux_Select}, {30'd0, vecs[i-1].wb});
        chk($sformatf("vec%0d_wp", i-1), {30'd0, writePortMux_Select}, {30'd0, vecs[i-1].wp});
        chk($sformatf("vec%0d_no_req", i-1), {31'd0, dmem_req}, 0);
      end
      prev = insn;
      tick();
    end
    #1;
    chk("idle_m_valid", {31'd0, m_valid}, 0);
    chk("idle_we_gated", {31'd0, regfile_WE}, 0);
    chk("idle_wb_gated", {30'd0, writebackMux_Select}, 0);
    chk("idle_m_insn_held", m_instruction, prev);

    // lw with three wait cycles
    tick();
    insn = mk(5'd8, 40);
    x_valid = 1'b1; x_instruction = insn;
    #1 chk("lw_accept_ready", {31'd0, x_ready}, 1);
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      #1;
      chk($sformatf("lw_c%0d_req", c), {31'd0, dmem_req}, 1);
      chk($sformatf("lw_c%0d_we", c), {31'd0, dmem_WE}, 0);
      chk($sformatf("lw_c%0d_x_ready", c), {31'd0, x_ready}, 0);
      chk($sformatf("lw_c%0d_m_valid", c), {31'd0, m_valid}, 0);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    chk("lw_done_m_valid", {31'd0, m_valid}, 1);
    chk("lw_done_wb", {30'd0, writebackMux_Select}, 2'b01);
    chk("lw_done_we", {31'd0, regfile_WE}, 1);
    chk("lw_done_req", {31'd0, dmem_req}, 0);
    chk("lw_done_insn", m_instruction, insn);
    tick();
    #1 chk("lw_after_m_valid", {31'd0, m_valid}, 0);

    // Zero-wait sw: request the cycle after accept, m_valid one cycle later
    insn = mk(5'd7, 41);
    x_valid = 1'b1; x_instruction = insn;
    tick();
    x_valid = 1'b0; dmem_ready = 1'b1;
    #1;
    chk("sw0_req", {31'd0, dmem_req}, 1);
    chk("sw0_we", {31'd0, dmem_WE}, 1);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("sw0_m_valid", {31'd0, m_valid}, 1);
    chk("sw0_rf_we", {31'd0, regfile_WE}, 0);
    chk("sw0_req_low", {31'd0, dmem_req}, 0);
    tick();

    // sw flushed in its 2nd ACCESS cycle, memory completes in the 4th
    insn = mk(5'd7, 42);
    x_valid = 1'b1; x_instruction = insn;
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      flush = (c == 1);
      dmem_ready = (c == 3);
      #1;
      chk($sformatf("swf_c%0d_req", c), {31'd0, dmem_req}, 1);
      chk($sformatf("swf_c%0d_we", c), {31'd0, dmem_WE}, 1);
      chk($sformatf("swf_c%0d_x_ready", c), {31'd0, x_ready}, 0);
      tick();
    end
    flush = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("swf_no_m_valid", {31'd0, m_valid}, 0);
    chk("swf_x_ready_back", {31'd0, x_ready}, 1);
    chk("swf_req_low", {31'd0, dmem_req}, 0);

    // lw flushed in ACCESS: request drops next cycle, no writeback
    x_valid = 1'b1; x_instruction = mk(5'd8, 43);
    tick();
    x_valid = 1'b0; flush = 1'b1;
    #1 chk("lwf_req_flush_cycle", {31'd0, dmem_req}, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("lwf_req_dropped", {31'd0, dmem_req}, 0);
    chk("lwf_no_m_valid", {31'd0, m_valid}, 0);
    chk("lwf_x_ready", {31'd0, x_ready}, 1);

    // Flush beats accept; flush in HOLD kills the held instruction
    x_valid = 1'b1; x_instruction = mk(5'd0, 44); flush = 1'b1;
    #1 chk("flush_blocks_ready", {31'd0, x_ready}, 0);
    tick();
    flush = 1'b0;
    #1 chk("flush_dropped_insn", {31'd0, m_valid}, 0);
    tick();
    flush = 1'b1;
    #1 chk("hold_visible", {31'd0, m_valid}, 1);
    tick();
    flush = 1'b0; x_valid = 1'b0;
    #1 chk("hold_flushed", {31'd0, m_valid}, 0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog abort after TIMEOUT_LIMIT stalled ACCESS cycles
    insn = mk(5'd8, 45);
    x_valid = 1'b1; x_instruction = insn;
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("tmo_c%0d_req", c), {31'd0, dmem_req}, 1);
      tick();
    end
    #1;
    chk("tmo_m_valid", {31'd0, m_valid}, 1);
    chk("tmo_we_suppressed", {31'd0, regfile_WE}, 0);
    chk("tmo_mem_err", {31'd0, mem_err}, 1);
    tick();
    tick();
    #1 chk("tmo_mem_err_sticky", {31'd0, mem_err}, 1);
`else
    #1 chk("no_tmo_mem_err", {31'd0, mem_err}, 0);
`endif

    // Reset mid-ACCESS drops everything asynchronously
    tick();
    x_valid = 1'b1; x_instruction = mk(5'd8, 46);
    tick();
    x_valid = 1'b0;
    #1 chk("rstacc_req_before", {31'd0, dmem_req}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstacc_req", {31'd0, dmem_req}, 0);
    chk("rstacc_m_valid", {31'd0, m_valid}, 0);
    chk("rstacc_x_ready", {31'd0, x_ready}, 0);
    chk("rstacc_insn", m_instruction, 0);
    chk("rstacc_mem_err", {31'd0, mem_err}, 0);
    reset = 1'b0;
    tick();
    #1;
    chk("rstacc_x_ready_after", {31'd0, x_ready}, 1);
    chk("rstacc_req_after", {31'd0, dmem_req}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Registered, handshaked memory-stage control unit for the 5-stage pipeline; successor to the combinational memory-stage decode.
- Latches the instruction leaving execute and decodes its opcode (bits [INSN_W-1 -: OPC_W]).
- Drives a variable-latency data memory through a req/ready handshake and back-pressures execute while an access is outstanding.
- Presents writeback controls (regfile WE, writeback mux, write-port mux) with a valid strobe to the writeback stage.

Parameters:
- INSN_W, 32, instruction width.
- OPC_W, 5, opcode width; opcode field is the top OPC_W bits.
- TIMEOUT_W, 8, watchdog counter width (used only with MEM_TIMEOUT_EN).
- TIMEOUT_LIMIT, 200, ACCESS cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- x_valid  input  1  execute presents an instruction.
- x_instruction  input  INSN_W  instruction from execute.
- x_ready  output  1  stage accepts this cycle; transfer = x_valid & x_ready.
- flush  input  1  kill held and incoming instruction.
- dmem_req  output  1  memory access request.
- dmem_WE  output  1  store; valid only with dmem_req.
- dmem_ready  input  1  memory completes the access this cycle.
- m_valid  output  1  writeback controls valid (one-cycle strobe per instruction).
- m_instruction  output  INSN_W  held instruction.
- regfile_WE  output  1  register write enable.
- writebackMux_Select  output  2  00 ALU, 01 dmem, 10 PC+1, 11 setx target.
- writePortMux_Select  output  2  00 rd, 10 r31 (jal), 01 r30 (setx).
- mem_err  output  1  sticky timeout flag.

Behaviour:
- Decode (opcode values):
  - ALU = 0, addi = 5, jal = 3, sw = 7, lw = 8, setx = 21.
  - regfile_WE for ALU, addi, lw, jal, setx.
  - writebackMux_Select[1] = jal | setx; writebackMux_Select[0] = lw | setx.
  - writePortMux_Select[1] = jal; writePortMux_Select[0] = setx.
  - Memory op = sw or lw.
- States: EMPTY, HOLD, ACCESS, DONE.
  - x_ready = ~flush & (state != ACCESS).
- From EMPTY, HOLD or DONE:
  - On accept, latch the instruction: memory op goes to ACCESS, otherwise to HOLD.
  - No accept: go to EMPTY.
- ACCESS:
  - dmem_req = 1; dmem_WE = 1 for sw.
  - dmem_ready goes to DONE; otherwise stay.
  - Request holds stable until dmem_ready.
- m_valid = 1 in HOLD and DONE only.
  - regfile_WE and both mux selects are forced to 0 whenever m_valid = 0.
  - m_instruction holds its last value.
- Latency:
  - Non-memory instruction: m_valid the cycle after accept.
  - Memory instruction: dmem_req the cycle after accept; m_valid the cycle after dmem_ready.
  - Zero-wait memory (dmem_ready in the first ACCESS cycle) gives 2 cycles.
- Back-to-back: accept in HOLD or DONE is allowed, giving one instruction per cycle for non-memory streams.
- Flush:
  - Has priority over accept; the incoming instruction is dropped.
  - HOLD, DONE or EMPTY go to EMPTY.
  - ACCESS with lw: go to EMPTY, request drops next cycle.
  - ACCESS with sw: store is not aborted. Stay in ACCESS until dmem_ready, then EMPTY with no m_valid. x_ready stays 0 until the store finishes.
- Reset (async): state EMPTY, all outputs 0, held instruction 0, mem_err 0.
- Reset mid-ACCESS drops dmem_req immediately.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - TIMEOUT_W counter clears on ACCESS entry and increments each ACCESS cycle without dmem_ready.
  - At TIMEOUT_LIMIT the block goes to DONE, sets mem_err (sticky until reset) and suppresses regfile_WE for that instruction; m_valid still pulses.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Decomposition:
- Package mem_ctrl_pkg:
  - opcode constants;
  - writeback and write-port select encodings;
  - 2-bit state encoding.
- Sub-module mem_ctrl_decode: combinational opcode-to-control decode, built on decoder5to32.

Test Plan:
- Reset asserted mid-ACCESS -> dmem_req, m_valid and x_ready drop to 0 asynchronously; after release, x_ready = 1 and state is EMPTY.
- Three back-to-back ALU instructions, x_valid held high -> m_valid high 3 consecutive cycles; regfile_WE = 1; selects 00/00; x_ready never drops.
- lw with dmem_ready after 3 wait cycles:
  - dmem_req high 4 cycles with dmem_WE = 0, x_ready low 4 cycles;
  - then one m_valid cycle with writebackMux_Select = 01, regfile_WE = 1.
- sw, flush raised in the 2nd ACCESS cycle, dmem_ready in the 4th:
  - dmem_req and dmem_WE stay high through the 4th cycle;
  - no m_valid; x_ready returns the next cycle.
- jal then setx back-to-back -> writePortMux_Select 10 then 01; writebackMux_Select 10 then 11.
- With MEM_TIMEOUT_EN, TIMEOUT_LIMIT = 4, lw, dmem_ready held 0:
  - after 4 ACCESS cycles, m_valid pulses with regfile_WE = 0;
  - mem_err = 1 and stays high.
